// File: rtl/ft245_fifo_responder_if.sv
// FT245-style asynchronous FIFO pin bundle between bridge (master) and
// device model (slave).
interface ft245_fifo_responder_if #(
   parameter int DATA_W = 8
);
   logic              rd_n;
   logic              wr_n;
   logic [DATA_W-1:0] din;
   logic [DATA_W-1:0] dout;
   logic              dout_oe;
   logic              rxf_n;
   logic              txe_n;

   modport master (
      output rd_n, wr_n, din,
      input  dout, dout_oe, rxf_n, txe_n
   );

   modport slave (
      input  rd_n, wr_n, din,
      output dout, dout_oe, rxf_n, txe_n
   );
endinterface

// File: rtl/ft245_fifo_responder.sv
// Device-side FT245 FIFO model: RX buffer read by rd_n strobes, TX buffer
// written by wr_n strobes, each flag held off for a recovery window.
module ft245_fifo_responder #(
   parameter int DATA_W       = 8,
   parameter int DEPTH        = 16,
   parameter int RECOVERY_CYC = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   ft245_fifo_responder_if.slave  pins,
   input  logic                   ld_valid,
   input  logic [DATA_W-1:0]      ld_data,
   output logic                   ld_ready,
   output logic                   dr_valid,
   output logic [DATA_W-1:0]      dr_data,
   input  logic                   dr_ready,
   output logic [$clog2(DEPTH):0] rx_level,
   output logic [$clog2(DEPTH):0] tx_level,
   output logic                   proto_err
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(RECOVERY_CYC + 1);

   typedef logic [AW:0] ptr_t;
   typedef enum logic [1:0] {
      R_IDLE  = 2'd0,
      R_READ  = 2'd1,
      R_RECOV = 2'd2
   } r_state_t;
   typedef enum logic [1:0] {
      W_IDLE  = 2'd0,
      W_WRITE = 2'd1,
      W_RECOV = 2'd2
   } w_state_t;

   logic rd_meta_q, rd_sync_q, rd_prev_q;
   logic wr_meta_q, wr_sync_q, wr_prev_q;
   logic rd_fall, rd_rise, wr_fall, wr_rise;

   r_state_t r_state_q, r_state_d;
   w_state_t w_state_q, w_state_d;
   logic [CW-1:0] r_cnt_q, r_cnt_d;
   logic [CW-1:0] w_cnt_q, w_cnt_d;

   logic [DATA_W-1:0] dout_q, dout_d;
   logic oe_q, oe_d;
   logic rxf_n_q, rxf_n_d;
   logic txe_n_q, txe_n_d;
   logic err_q, err_d;

   ptr_t rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
   ptr_t tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
   ptr_t rx_level_d, tx_level_d;
   logic rx_push, rx_pop, tx_push, tx_pop;
   logic rx_full, tx_empty;

   logic [DATA_W-1:0] rx_mem [DEPTH];
   logic [DATA_W-1:0] tx_mem [DEPTH];

   function automatic logic is_full(ptr_t w, ptr_t r);
      return (w[AW] != r[AW]) && (w[AW-1:0] == r[AW-1:0]);
   endfunction

   assign rd_fall = rd_prev_q & ~rd_sync_q;
   assign rd_rise = ~rd_prev_q & rd_sync_q;
   assign wr_fall = wr_prev_q & ~wr_sync_q;
   assign wr_rise = ~wr_prev_q & wr_sync_q;

   assign rx_full  = is_full(rx_wptr_q, rx_rptr_q);
   assign tx_empty = (tx_wptr_q == tx_rptr_q);
   assign rx_push  = ld_valid & ~rx_full;
   assign tx_pop   = dr_ready & ~tx_empty;

   always_comb begin
      r_state_d = r_state_q;
      w_state_d = w_state_q;
      r_cnt_d   = r_cnt_q;
      w_cnt_d   = w_cnt_q;
      dout_d    = dout_q;
      oe_d      = oe_q;
      err_d     = err_q;
      rx_pop    = 1'b0;
      tx_push   = 1'b0;

      unique case (r_state_q)
         R_IDLE: begin
            if (rd_fall) begin
               if (rxf_n_q) begin
                  err_d = 1'b1;
               end else begin
                  dout_d    = rx_mem[rx_rptr_q[AW-1:0]];
                  oe_d      = 1'b1;
                  r_state_d = R_READ;
               end
            end
         end
         R_READ: begin
            if (rd_rise) begin
               rx_pop    = 1'b1;
               oe_d      = 1'b0;
               r_cnt_d   = CW'(RECOVERY_CYC);
               r_state_d = R_RECOV;
            end
         end
         R_RECOV: begin
            if (rd_fall) err_d = 1'b1;
            if (r_cnt_q <= CW'(1)) begin
               r_cnt_d   = '0;
               r_state_d = R_IDLE;
            end else begin
               r_cnt_d = r_cnt_q - CW'(1);
            end
         end
         default: r_state_d = R_IDLE;
      endcase

      unique case (w_state_q)
         W_IDLE: begin
            if (wr_fall) begin
               if (txe_n_q) begin
                  err_d = 1'b1;
               end else begin
                  tx_push   = 1'b1;
                  w_state_d = W_WRITE;
               end
            end
         end
         W_WRITE: begin
            if (wr_rise) begin
               w_cnt_d   = CW'(RECOVERY_CYC);
               w_state_d = W_RECOV;
            end
         end
         W_RECOV: begin
            if (wr_fall) err_d = 1'b1;
            if (w_cnt_q <= CW'(1)) begin
               w_cnt_d   = '0;
               w_state_d = W_IDLE;
            end else begin
               w_cnt_d = w_cnt_q - CW'(1);
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      rx_wptr_d  = rx_wptr_q + ptr_t'(rx_push);
      rx_rptr_d  = rx_rptr_q + ptr_t'(rx_pop);
      tx_wptr_d  = tx_wptr_q + ptr_t'(tx_push);
      tx_rptr_d  = tx_rptr_q + ptr_t'(tx_pop);
      rx_level_d = rx_wptr_d - rx_rptr_d;
      tx_level_d = tx_wptr_d - tx_rptr_d;
      // Flags are registered from next state/level so the pins never glitch
      rxf_n_d = (r_state_d != R_IDLE) || (rx_level_d == '0);
      txe_n_d = (w_state_d != W_IDLE) || (tx_level_d == ptr_t'(DEPTH));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_meta_q <= 1'b1;
         rd_sync_q <= 1'b1;
         rd_prev_q <= 1'b1;
         wr_meta_q <= 1'b1;
         wr_sync_q <= 1'b1;
         wr_prev_q <= 1'b1;
         r_state_q <= R_IDLE;
         w_state_q <= W_IDLE;
         r_cnt_q   <= '0;
         w_cnt_q   <= '0;
         dout_q    <= '0;
         oe_q      <= 1'b0;
         rxf_n_q   <= 1'b1;
         txe_n_q   <= 1'b1;
         err_q     <= 1'b0;
         rx_wptr_q <= '0;
         rx_rptr_q <= '0;
         tx_wptr_q <= '0;
         tx_rptr_q <= '0;
      end else begin
         rd_meta_q <= pins.rd_n;
         rd_sync_q <= rd_meta_q;
         rd_prev_q <= rd_sync_q;
         wr_meta_q <= pins.wr_n;
         wr_sync_q <= wr_meta_q;
         wr_prev_q <= wr_sync_q;
         r_state_q <= r_state_d;
         w_state_q <= w_state_d;
         r_cnt_q   <= r_cnt_d;
         w_cnt_q   <= w_cnt_d;
         dout_q    <= dout_d;
         oe_q      <= oe_d;
         rxf_n_q   <= rxf_n_d;
         txe_n_q   <= txe_n_d;
         err_q     <= err_d;
         rx_wptr_q <= rx_wptr_d;
         rx_rptr_q <= rx_rptr_d;
         tx_wptr_q <= tx_wptr_d;
         tx_rptr_q <= tx_rptr_d;
      end
   end

   // din is captured straight off the pins; the bridge holds it past the fall edge
   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wptr_q[AW-1:0]] <= ld_data;
      if (tx_push) tx_mem[tx_wptr_q[AW-1:0]] <= pins.din;
   end

   assign pins.dout    = dout_q;
   assign pins.dout_oe = oe_q;
   assign pins.rxf_n   = rxf_n_q;
   assign pins.txe_n   = txe_n_q;

   assign ld_ready  = ~rx_full;
   assign dr_valid  = ~tx_empty;
   assign dr_data   = tx_mem[tx_rptr_q[AW-1:0]];
   assign rx_level  = rx_wptr_q - rx_rptr_q;
   assign tx_level  = tx_wptr_q - tx_rptr_q;
   assign proto_err = err_q;
endmodule

// File: tb/tb_ft245_fifo_responder.sv
// Bench for ft245_fifo_responder: randomized strobes and loads against a
// queue-based model of the two buffers and the flag timing rules.
module tb_ft245_fifo_responder;
   localparam int RC  = 4;
   localparam int RA  = 1;
   localparam int RB  = 7;
   localparam int BND = 40;
   localparam int DEP = 16;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   ft245_fifo_responder_if #(.DATA_W(8)) pm ();
   ft245_fifo_responder_if #(.DATA_W(8)) pa ();
   ft245_fifo_responder_if #(.DATA_W(8)) pb ();

   logic       ld_valid, ld_ready, dr_valid, dr_ready, proto_err;
   logic [7:0] ld_data, dr_data;
   logic [4:0] rx_level, tx_level;

   logic       ld_valid_s, dr_ready_s;
   logic [7:0] ld_data_s;
   logic       ld_ready_a, dr_valid_a, err_a;
   logic       ld_ready_b, dr_valid_b, err_b;
   logic [7:0] dr_data_a, dr_data_b;
   logic [4:0] rx_level_a, tx_level_a, rx_level_b, tx_level_b;

   ft245_fifo_responder #(.DATA_W(8), .DEPTH(DEP), .RECOVERY_CYC(RC)) u_dut (
      .clk(clk), .rst_n(rst_n), .pins(pm),
      .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
      .dr_valid(dr_valid), .dr_data(dr_data), .dr_ready(dr_ready),
      .rx_level(rx_level), .tx_level(tx_level), .proto_err(proto_err)
   );

   ft245_fifo_responder #(.DATA_W(8), .DEPTH(DEP), .RECOVERY_CYC(RA)) u_ra (
      .clk(clk), .rst_n(rst_n), .pins(pa),
      .ld_valid(ld_valid_s), .ld_data(ld_data_s), .ld_ready(ld_ready_a),
      .dr_valid(dr_valid_a), .dr_data(dr_data_a), .dr_ready(dr_ready_s),
      .rx_level(rx_level_a), .tx_level(tx_level_a), .proto_err(err_a)
   );

   ft245_fifo_responder #(.DATA_W(8), .DEPTH(DEP), .RECOVERY_CYC(RB)) u_rb (
      .clk(clk), .rst_n(rst_n), .pins(pb),
      .ld_valid(ld_valid_s), .ld_data(ld_data_s), .ld_ready(ld_ready_b),
      .dr_valid(dr_valid_b), .dr_data(dr_data_b), .dr_ready(dr_ready_s),
      .rx_level(rx_level_b), .tx_level(tx_level_b), .proto_err(err_b)
   );

   logic [7:0] rx_q[$];
   logic [7:0] tx_q[$];
   logic       exp_err;
   int         pushes, pops_done;
   bit         mon_on;

   always @(negedge clk) begin
      if (mon_on) begin
         checks++;
         if (rx_level !== 5'(pushes - pops_done)) begin
            failures++;
            $display("FAIL t3_level got=%0d exp=%0d", rx_level, pushes - pops_done);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ld_byte(input logic [7:0] v, output bit ok);
      int n;
      logic r;
      n = 0;
      ok = 0;
      ld_valid = 1'b1;
      ld_data = v;
      while (n < 300) begin
         r = ld_ready;
         tick();
         n++;
         if (r) begin
            ok = 1;
            break;
         end
      end
      ld_valid = 1'b0;
      if (ok) begin
         rx_q.push_back(v);
         pushes++;
      end
   endtask

   task automatic rd_pulse(input int low, output logic [7:0] d,
                           output logic oe, output logic mid, output int hi);
      pm.rd_n = 1'b0;
      repeat (low) tick();
      d = pm.dout;
      oe = pm.dout_oe;
      mid = pm.rxf_n;
      pm.rd_n = 1'b1;
      hi = BND;
      for (int k = 1; k <= BND; k++) begin
         tick();
         if (k == 3) pops_done++;
         if (!pm.rxf_n) begin
            hi = k - 1;
            break;
         end
      end
   endtask

   task automatic wr_pulse(input int low, input logic [7:0] v,
                           output logic mid, output int hi);
      pm.din = v;
      pm.wr_n = 1'b0;
      repeat (low) tick();
      mid = pm.txe_n;
      pm.wr_n = 1'b1;
      hi = BND;
      for (int k = 1; k <= BND; k++) begin
         tick();
         if (!pm.txe_n) begin
            hi = k - 1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      checks++;
      if (pm.rxf_n !== 1'b1 || pm.txe_n !== 1'b1 || pm.dout_oe !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags got=%b%b%b exp=110", pm.rxf_n, pm.txe_n, pm.dout_oe);
      end
      checks++;
      if (pm.dout !== 8'h00 || rx_level !== 5'd0 || tx_level !== 5'd0) begin
         failures++;
         $display("FAIL reset_data got=%0h/%0d/%0d exp=0/0/0", pm.dout, rx_level, tx_level);
      end
      checks++;
      if (dr_valid !== 1'b0 || ld_ready !== 1'b1 || proto_err !== 1'b0) begin
         failures++;
         $display("FAIL reset_hs got=%b%b%b exp=010", dr_valid, ld_ready, proto_err);
      end
   endtask

   task automatic test_read_basic();
      logic [7:0] d, e;
      logic oe, mid;
      int hi, eh;
      bit ok;
      checks++;
      if (pm.rxf_n !== 1'b1) begin
         failures++;
         $display("FAIL t1_rxf_empty got=%b exp=1", pm.rxf_n);
      end
      ld_byte(8'hA5, ok);
      checks++;
      if (!ok || pm.rxf_n !== 1'b0) begin
         failures++;
         $display("FAIL t1_rxf_fall got=%b exp=0", pm.rxf_n);
      end
      ld_byte(8'h3C, ok);
      checks++;
      if (rx_level !== 5'd2) begin
         failures++;
         $display("FAIL t1_level got=%0d exp=2", rx_level);
      end
      for (int i = 0; i < 2; i++) begin
         rd_pulse(8, d, oe, mid, hi);
         e = rx_q.pop_front();
         eh = (rx_q.size() > 0) ? 2 + RC : BND;
         checks++;
         if (d !== e || oe !== 1'b1 || mid !== 1'b1) begin
            failures++;
            $display("FAIL t1_read%0d got=%0h/%b/%b exp=%0h/1/1", i, d, oe, mid, e);
         end
         checks++;
         if (hi !== eh) begin
            failures++;
            $display("FAIL t1_window%0d got=%0d exp=%0d", i, hi, eh);
         end
      end
      checks++;
      if (rx_level !== 5'd0 || pm.dout_oe !== 1'b0 || proto_err !== exp_err) begin
         failures++;
         $display("FAIL t1_end got=%0d/%b/%b exp=0/0/%b", rx_level, pm.dout_oe, proto_err, exp_err);
      end
   endtask

   task automatic test_stream();
      pushes = 0;
      pops_done = 0;
      mon_on = 1;
      fork
         begin : loader
            bit ok;
            for (int i = 0; i < 40; i++) begin
               ld_byte(8'($urandom), ok);
               checks++;
               if (!ok) begin
                  failures++;
                  $display("FAIL t3_load idx=%0d got=stall exp=accept", i);
               end
               repeat ($urandom_range(0, 2)) tick();
            end
         end
         begin : reader
            logic [7:0] d, e;
            logic oe, mid;
            int hi, w;
            for (int i = 0; i < 40; i++) begin
               w = 0;
               while (pm.rxf_n && w < 400) begin
                  tick();
                  w++;
               end
               checks++;
               if (pm.rxf_n) begin
                  failures++;
                  $display("FAIL t3_wait idx=%0d got=rxf_n=1 exp=0", i);
                  break;
               end
               rd_pulse($urandom_range(3, 5), d, oe, mid, hi);
               e = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
               checks++;
               if (d !== e || oe !== 1'b1) begin
                  failures++;
                  $display("FAIL t3_data idx=%0d got=%0h/%b exp=%0h/1", i, d, oe, e);
               end
            end
         end
      join
      mon_on = 0;
      checks++;
      if (rx_level !== 5'd0 || proto_err !== exp_err) begin
         failures++;
         $display("FAIL t3_end got=%0d/%b exp=0/%b", rx_level, proto_err, exp_err);
      end
   endtask

   task automatic test_simul();
      logic [7:0] dv, e;
      int rh, th;
      bit ok;
      ld_byte(8'($urandom), ok);
      ld_byte(8'($urandom), ok);
      checks++;
      if (pm.rxf_n !== 1'b0 || pm.txe_n !== 1'b0) begin
         failures++;
         $display("FAIL t4_pre got=%b%b exp=00", pm.rxf_n, pm.txe_n);
      end
      dv = 8'($urandom);
      pm.din = dv;
      pm.rd_n = 1'b0;
      pm.wr_n = 1'b0;
      repeat (4) tick();
      e = rx_q[0];
      checks++;
      if (pm.dout !== e || pm.dout_oe !== 1'b1) begin
         failures++;
         $display("FAIL t4_dout got=%0h/%b exp=%0h/1", pm.dout, pm.dout_oe, e);
      end
      checks++;
      if (tx_level !== 5'd1 || dr_data !== dv || rx_level !== 5'd2) begin
         failures++;
         $display("FAIL t4_push got=%0d/%0h/%0d exp=1/%0h/2", tx_level, dr_data, rx_level, dv);
      end
      pm.rd_n = 1'b1;
      void'(rx_q.pop_front());
      rh = BND;
      th = BND;
      for (int k = 1; k <= BND; k++) begin
         tick();
         if (k == 2) pm.wr_n = 1'b1;
         if (!pm.rxf_n && rh == BND) rh = k - 1;
         if (!pm.txe_n && th == BND) th = k - 1;
      end
      checks++;
      if (rh !== 2 + RC || th !== 4 + RC) begin
         failures++;
         $display("FAIL t4_windows got=%0d/%0d exp=%0d/%0d", rh, th, 2 + RC, 4 + RC);
      end
      checks++;
      if (rx_level !== 5'(rx_q.size())) begin
         failures++;
         $display("FAIL t4_pop got=%0d exp=%0d", rx_level, rx_q.size());
      end
      dr_ready = 1'b1;
      tick();
      dr_ready = 1'b0;
      checks++;
      if (tx_level !== 5'd0 || dr_valid !== 1'b0 || proto_err !== exp_err) begin
         failures++;
         $display("FAIL t4_drain got=%0d/%b/%b exp=0/0/%b", tx_level, dr_valid, proto_err, exp_err);
      end
   endtask

   task automatic test_tx_overflow();
      logic mid;
      int hi, eh;
      logic [7:0] e;
      for (int i = 0; i < 20; i++) begin
         wr_pulse($urandom_range(3, 6), 8'(i), mid, hi);
         if (tx_q.size() < DEP) tx_q.push_back(8'(i));
         else exp_err = 1'b1;
         eh = (tx_q.size() < DEP) ? 2 + RC : BND;
         checks++;
         if (hi !== eh || mid !== 1'b1) begin
            failures++;
            $display("FAIL t2_pulse%0d got=%0d/%b exp=%0d/1", i, hi, mid, eh);
         end
      end
      checks++;
      if (tx_level !== 5'(tx_q.size()) || proto_err !== exp_err) begin
         failures++;
         $display("FAIL t2_full got=%0d/%b exp=%0d/%b", tx_level, proto_err, tx_q.size(), exp_err);
      end
      while (tx_q.size() > 0) begin
         e = tx_q.pop_front();
         checks++;
         if (dr_valid !== 1'b1 || dr_data !== e) begin
            failures++;
            $display("FAIL t2_drain got=%b/%0h exp=1/%0h", dr_valid, dr_data, e);
         end
         dr_ready = 1'b1;
         tick();
         dr_ready = 1'b0;
      end
      checks++;
      if (tx_level !== 5'd0 || pm.txe_n !== 1'b0) begin
         failures++;
         $display("FAIL t2_empty got=%0d/%b exp=0/0", tx_level, pm.txe_n);
      end
   endtask

   task automatic test_async_reset();
      bit ok;
      ld_byte(8'($urandom), ok);
      pm.rd_n = 1'b0;
      repeat (4) tick();
      checks++;
      if (pm.dout_oe !== 1'b1 || pm.dout !== rx_q[0]) begin
         failures++;
         $display("FAIL t5_read got=%b/%0h exp=1/%0h", pm.dout_oe, pm.dout, rx_q[0]);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (pm.dout_oe !== 1'b0 || pm.dout !== 8'h00 || pm.rxf_n !== 1'b1 || pm.txe_n !== 1'b1) begin
         failures++;
         $display("FAIL t5_pins got=%b/%0h/%b%b exp=0/0/11", pm.dout_oe, pm.dout, pm.rxf_n, pm.txe_n);
      end
      checks++;
      if (rx_level !== 5'd0 || proto_err !== 1'b0 || ld_ready !== 1'b1 || dr_valid !== 1'b0) begin
         failures++;
         $display("FAIL t5_state got=%0d/%b/%b/%b exp=0/0/1/0", rx_level, proto_err, ld_ready, dr_valid);
      end
      pm.rd_n = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      rx_q.delete();
      tx_q.delete();
      exp_err = 1'b0;
      repeat (6) tick();
      checks++;
      if (rx_level !== 5'd0 || pm.rxf_n !== 1'b1 || pm.txe_n !== 1'b0 || proto_err !== exp_err) begin
         failures++;
         $display("FAIL t5_after got=%0d/%b%b/%b exp=0/10/0", rx_level, pm.rxf_n, pm.txe_n, proto_err);
      end
   endtask

   task automatic test_recovery_sweep();
      logic [7:0] b0, b1, v;
      int ha, hb;
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      ld_valid_s = 1'b1;
      ld_data_s = b0;
      tick();
      ld_data_s = b1;
      tick();
      ld_valid_s = 1'b0;
      checks++;
      if (rx_level_a !== 5'd2 || rx_level_b !== 5'd2) begin
         failures++;
         $display("FAIL t6_load got=%0d/%0d exp=2/2", rx_level_a, rx_level_b);
      end
      pa.rd_n = 1'b0;
      pb.rd_n = 1'b0;
      repeat (4) tick();
      checks++;
      if (pa.dout !== b0 || pb.dout !== b0 || pa.dout_oe !== 1'b1 || pb.dout_oe !== 1'b1) begin
         failures++;
         $display("FAIL t6_dout got=%0h/%0h exp=%0h", pa.dout, pb.dout, b0);
      end
      pa.rd_n = 1'b1;
      pb.rd_n = 1'b1;
      ha = BND;
      hb = BND;
      for (int k = 1; k <= BND; k++) begin
         tick();
         if (!pa.rxf_n && ha == BND) ha = k - 1;
         if (!pb.rxf_n && hb == BND) hb = k - 1;
      end
      checks++;
      if (ha !== 2 + RA || hb !== 2 + RB) begin
         failures++;
         $display("FAIL t6_rx_window got=%0d/%0d exp=%0d/%0d", ha, hb, 2 + RA, 2 + RB);
      end
      v = 8'($urandom);
      pa.din = v;
      pb.din = v;
      pa.wr_n = 1'b0;
      pb.wr_n = 1'b0;
      repeat (4) tick();
      pa.wr_n = 1'b1;
      pb.wr_n = 1'b1;
      ha = BND;
      hb = BND;
      for (int k = 1; k <= BND; k++) begin
         tick();
         if (!pa.txe_n && ha == BND) ha = k - 1;
         if (!pb.txe_n && hb == BND) hb = k - 1;
      end
      checks++;
      if (ha !== 2 + RA || hb !== 2 + RB) begin
         failures++;
         $display("FAIL t6_tx_window got=%0d/%0d exp=%0d/%0d", ha, hb, 2 + RA, 2 + RB);
      end
      checks++;
      if (dr_data_a !== v || dr_data_b !== v || tx_level_b !== 5'd1 || err_a !== 1'b0) begin
         failures++;
         $display("FAIL t6_tx_data got=%0h/%0h/%0d exp=%0h/%0h/1", dr_data_a, dr_data_b, tx_level_b, v, v);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      rst_n = 1'b0;
      pm.rd_n = 1'b1;
      pm.wr_n = 1'b1;
      pm.din = 8'h00;
      pa.rd_n = 1'b1;
      pa.wr_n = 1'b1;
      pa.din = 8'h00;
      pb.rd_n = 1'b1;
      pb.wr_n = 1'b1;
      pb.din = 8'h00;
      ld_valid = 1'b0;
      ld_data = 8'h00;
      dr_ready = 1'b0;
      ld_valid_s = 1'b0;
      ld_data_s = 8'h00;
      dr_ready_s = 1'b0;
      mon_on = 0;
      exp_err = 1'b0;
      pushes = 0;
      pops_done = 0;
      repeat (3) tick();
      test_reset();
      rst_n = 1'b1;
      repeat (3) tick();
      test_read_basic();
      test_stream();
      test_simul();
      test_tx_overflow();
      test_async_reset();
      test_recovery_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
